// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue in front of the register-file write port.
// Exposes a pending-write scoreboard and newest-value forwarding for decode.
module regfile_writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_reg,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      drain_en,
  output logic [ADDR_WIDTH-1:0]     write_reg,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic                      reg_write,
  input  logic [ADDR_WIDTH-1:0]     lookup_reg,
  output logic                      fwd_hit,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic [(1<<ADDR_WIDTH)-1:0] pending,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] mem_reg_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_reg_d  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  reg_write_q, reg_write_d;
  logic                  push, pop;

  // Handshake: a result transfers on a rising edge where in_valid && in_ready;
  // the producer holds reg/data stable until then. in_ready depends only on
  // occupancy, so a full queue never accepts even when it pops that edge.
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = drain_en && (count_q != '0);

  always_comb begin
    mem_reg_d    = mem_reg_q;
    mem_data_d   = mem_data_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;

    if (push) begin
      mem_reg_d[tail_q]  = in_reg;
      mem_data_d[tail_q] = in_data;
      tail_d             = tail_q + PW'(1);
    end

    if (pop) begin
      write_reg_d  = mem_reg_q[head_q];
      write_data_d = mem_data_q[head_q];
      reg_write_d  = 1'b1;
      head_d       = head_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg_q[i]  <= '0;
        mem_data_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      mem_reg_q    <= mem_reg_d;
      mem_data_q   <= mem_data_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
    end
  end

  // Sources are scanned oldest first, so a later (newer) match overrides:
  // output stage, then queue entries from head towards tail.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    pending  = '0;
    idx      = '0;
    if (reg_write_q) begin
      pending[write_reg_q] = 1'b1;
      if (write_reg_q == lookup_reg) begin
        fwd_hit  = 1'b1;
        fwd_data = write_data_q;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        pending[mem_reg_q[idx]] = 1'b1;
        if (mem_reg_q[idx] == lookup_reg) begin
          fwd_hit  = 1'b1;
          fwd_data = mem_data_q[idx];
        end
      end
    end
  end

  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign reg_write  = reg_write_q;
  assign count      = count_q;

  logic unused_nreg;
  assign unused_nreg = (NREG == 0);

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: vector table plus hand-written sequences
// for full/drain, pointer wrap and mid-operation reset, with a register-file model.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_reg;
  logic [31:0] in_data;
  logic        drain_en;
  logic [2:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [2:0]  lookup_reg;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [7:0]  pending;
  logic [2:0]  count;

  regfile_writeback_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .drain_en(drain_en),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .lookup_reg(lookup_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic        mon_en = 1'b0;
  logic [34:0] exp_q[$];
  logic [31:0] rf [8];

  // Register file: commits on the falling edge while reg_write is high
  always @(negedge clk) begin
    if (reg_write) rf[write_reg] <= write_data;
  end

  // Scoreboard: every commit must match the oldest accepted entry
  always @(negedge clk) begin
    logic [34:0] exp_v;
    if (mon_en && !rst && reg_write) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL commit_unexpected: got reg %0d data %0h, required no write", write_reg, write_data);
      end else begin
        exp_v = exp_q.pop_front();
        if ({write_reg, write_data} !== exp_v) begin
          n_fail++;
          $display("FAIL commit_order: got %0h, required %0h", {write_reg, write_data}, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [2:0]  ireg;
    logic [31:0] idata;
    logic        drain;
    logic [2:0]  lk;
    logic        rw;
    logic [2:0]  wr;
    logic [31:0] wd;
    logic [2:0]  cnt;
    logic        rdy;
    logic        hit;
    logic [31:0] fd;
    logic [7:0]  pend;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic iv, input logic [2:0] ireg, input logic [31:0] idata,
                              input logic drain, input logic [2:0] lk, input logic rw,
                              input logic [2:0] wr, input logic [31:0] wd, input logic [2:0] cnt,
                              input logic rdy, input logic hit, input logic [31:0] fd,
                              input logic [7:0] pend);
    vec_t v;
    v.iv = iv; v.ireg = ireg; v.idata = idata; v.drain = drain; v.lk = lk;
    v.rw = rw; v.wr = wr; v.wd = wd; v.cnt = cnt; v.rdy = rdy; v.hit = hit;
    v.fd = fd; v.pend = pend;
    return v;
  endfunction

  // Each vector: drive inputs, check outputs of the current state, then clock
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = vecs[i].iv; in_reg = vecs[i].ireg; in_data = vecs[i].idata;
      drain_en = vecs[i].drain; lookup_reg = vecs[i].lk;
      #2;
      chk($sformatf("vec%0d", i),
          96'({reg_write, write_reg, write_data, count, in_ready, fwd_hit, fwd_data, pending}),
          96'({vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].cnt, vecs[i].rdy, vecs[i].hit,
               vecs[i].fd, vecs[i].pend}));
      @(posedge clk); #1;
    end
  endtask

  task automatic push_one(input logic [2:0] r, input logic [31:0] d);
    int budget = 20;
    in_valid = 1'b1; in_reg = r; in_data = d;
    while (1) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back({r, d});
        #1;
        in_valid = 1'b0;
        chk("count_bound", 96'(count <= 3'd4), 96'(1));
        break;
      end
      @(posedge clk); #1;
      budget--;
      if (budget == 0) begin
        chk("push_timeout", 96'(0), 96'(1));
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_empty(input string name);
    bit done = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (count == 3'd0 && exp_q.size() == 0 && reg_write == 1'b0) begin
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(name, 96'(done), 96'(1));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
    vecs[0]  = mk(0, 0, 32'h0,        1, 3, 0, 0, 32'h0,        0, 1, 0, 32'h0,        8'h00);
    vecs[1]  = mk(1, 3, 32'hDEADBEEF, 1, 3, 0, 0, 32'h0,        0, 1, 0, 32'h0,        8'h00);
    vecs[2]  = mk(0, 0, 32'h0,        1, 3, 0, 0, 32'h0,        1, 1, 1, 32'hDEADBEEF, 8'h08);
    vecs[3]  = mk(0, 0, 32'h0,        1, 3, 1, 3, 32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF, 8'h08);
    vecs[4]  = mk(0, 0, 32'h0,        1, 3, 0, 3, 32'hDEADBEEF, 0, 1, 0, 32'h0,        8'h00);
    vecs[5]  = mk(1, 1, 32'h101,      0, 0, 0, 3, 32'hDEADBEEF, 0, 1, 0, 32'h0,        8'h00);
    vecs[6]  = mk(1, 2, 32'h102,      0, 0, 0, 3, 32'hDEADBEEF, 1, 1, 0, 32'h0,        8'h02);
    vecs[7]  = mk(1, 3, 32'h103,      0, 0, 0, 3, 32'hDEADBEEF, 2, 1, 0, 32'h0,        8'h06);
    vecs[8]  = mk(1, 4, 32'h104,      0, 0, 0, 3, 32'hDEADBEEF, 3, 1, 0, 32'h0,        8'h0E);
    vecs[9]  = mk(1, 5, 32'h105,      0, 0, 0, 3, 32'hDEADBEEF, 4, 0, 0, 32'h0,        8'h1E);
    vecs[10] = mk(1, 5, 32'h105,      1, 0, 0, 3, 32'hDEADBEEF, 4, 0, 0, 32'h0,        8'h1E);
    vecs[11] = mk(0, 0, 32'h0,        1, 0, 1, 1, 32'h101,      3, 1, 0, 32'h0,        8'h1E);
    vecs[12] = mk(0, 0, 32'h0,        1, 4, 1, 2, 32'h102,      2, 1, 1, 32'h104,      8'h1C);
    vecs[13] = mk(0, 0, 32'h0,        1, 0, 1, 3, 32'h103,      1, 1, 0, 32'h0,        8'h18);
    vecs[14] = mk(0, 0, 32'h0,        1, 4, 1, 4, 32'h104,      0, 1, 1, 32'h104,      8'h10);
    vecs[15] = mk(0, 0, 32'h0,        1, 0, 0, 4, 32'h104,      0, 1, 0, 32'h0,        8'h00);
    vecs[16] = mk(1, 5, 32'h11,       0, 5, 0, 4, 32'h104,      0, 1, 0, 32'h0,        8'h00);
    vecs[17] = mk(1, 5, 32'h22,       0, 5, 0, 4, 32'h104,      1, 1, 1, 32'h11,       8'h20);
    vecs[18] = mk(0, 0, 32'h0,        0, 5, 0, 4, 32'h104,      2, 1, 1, 32'h22,       8'h20);
    vecs[19] = mk(0, 0, 32'h0,        1, 5, 0, 4, 32'h104,      2, 1, 1, 32'h22,       8'h20);
    vecs[20] = mk(0, 0, 32'h0,        1, 5, 1, 5, 32'h11,       1, 1, 1, 32'h22,       8'h20);
    vecs[21] = mk(0, 0, 32'h0,        1, 5, 1, 5, 32'h22,       0, 1, 1, 32'h22,       8'h20);
    vecs[22] = mk(0, 0, 32'h0,        0, 5, 0, 5, 32'h22,       0, 1, 0, 32'h0,        8'h00);

    // Clock/reset
    rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; drain_en = 1'b0; lookup_reg = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single push, then full/stall/drain, then same-register forwarding
    run_vecs(0, 4);
    chk("rf3_after_single", 96'(rf[3]), 96'(32'hDEADBEEF));
    run_vecs(5, 22);
    chk("rf1", 96'(rf[1]), 96'(32'h101));
    chk("rf2", 96'(rf[2]), 96'(32'h102));
    chk("rf3", 96'(rf[3]), 96'(32'h103));
    chk("rf4", 96'(rf[4]), 96'(32'h104));
    chk("rf5_last_wins", 96'(rf[5]), 96'(32'h22));

    // Full queue with drain enabled and producer holding valid
    mon_en = 1'b1;
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push_one(3'(i), 32'hA0 + 32'(i));
    #2;
    chk("full_count", 96'(count), 96'(3'd4));
    chk("full_not_ready", 96'(in_ready), 96'(0));
    drain_en = 1'b1; in_valid = 1'b1; in_reg = 3'd7; in_data = 32'hA4;
    chk("full_no_passthru", 96'(in_ready), 96'(0));
    @(posedge clk); #2;
    chk("ready_after_pop", 96'(in_ready), 96'(1));
    @(posedge clk); #1;
    exp_q.push_back({3'd7, 32'hA4});
    in_valid = 1'b0;
    for (int i = 5; i < 10; i++) push_one(3'(i), 32'hA0 + 32'(i));
    wait_empty("full_drain_done");

    // Back-to-back push/pop across pointer wrap
    for (int i = 0; i < 10; i++) push_one(3'((i + 3) % 8), 32'hB0 + 32'(i));
    wait_empty("wrap_drain_done");

    // Asynchronous reset with entries queued and a write in flight
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push_one(3'(i + 2), 32'hC0 + 32'(i));
    drain_en = 1'b1;
    @(posedge clk); #1;
    drain_en = 1'b0;
    #1;
    chk("pre_rst_state", 96'({reg_write, count}), 96'({1'b1, 3'd3}));
    #1 rst = 1'b1;
    #1;
    chk("rst_async_outputs", 96'({reg_write, count, pending, in_ready, fwd_hit}),
        96'({1'b0, 3'd0, 8'h00, 1'b1, 1'b0}));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    drain_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", 96'({reg_write, count}), 96'({1'b0, 3'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
